// File: rtl/count_pwm_stage.sv
// count_pwm_stage
//   Turns the upstream free-running count into a PWM ramp and compares it
//   against an active duty to produce a registered PWM output.
//   A new duty is accepted through a valid/ready handshake into a one-entry
//   pending slot. It becomes active only on a counter wrap (MAX->0), so a
//   PWM period never glitches. The block also flags wrap events and a
//   counter that has stopped advancing.
//
// Ports
//   iClk        rising-edge clock
//   iRst        asynchronous active-high reset
//   iCuenta     count value from the upstream counter (WIDTH bits)
//   iDuty       requested duty, 0..2^WIDTH high cycles per period
//   iDutyValid  iDuty is valid
//   oDutyReady  pending slot empty, a new duty can be accepted
//   oPwm        registered PWM output
//   oWrap       one-cycle pulse after a MAX->0 wrap is sampled
//   oStall      count unchanged for STALL_LIMIT consecutive samples
module count_pwm_stage #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned STALL_LIMIT = 8,
   parameter int unsigned DUTY_INIT   = 0
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic [WIDTH-1:0] iCuenta,
   input  logic [WIDTH:0]   iDuty,
   input  logic             iDutyValid,
   output logic             oDutyReady,
   output logic             oPwm,
   output logic             oWrap,
   output logic             oStall
);

   localparam logic [WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [WIDTH:0]   DUTY_FULL = {1'b1, {WIDTH{1'b0}}};
   localparam logic [7:0]       LIMIT     = 8'(STALL_LIMIT);

   logic [WIDTH-1:0] prev_q, prev_d;
   logic [7:0]       stall_cnt_q, stall_cnt_d;
   logic [WIDTH:0]   active_q, active_d;
   logic [WIDTH:0]   pend_q, pend_d;
   logic             pend_full_q, pend_full_d;
   logic             pwm_q, pwm_d;
   logic             wrap_q, wrap_d;
   logic             stall_q, stall_d;

   logic             wrap_ev;
   logic             xfer;
   logic             same;
   logic [WIDTH:0]   duty_sat;

   always_comb begin
      wrap_ev  = (prev_q == CNT_MAX) && (iCuenta == '0);
      xfer     = iDutyValid && !pend_full_q;
      same     = (iCuenta == prev_q);
      duty_sat = (iDuty > DUTY_FULL) ? DUTY_FULL : iDuty;

      prev_d      = iCuenta;
      active_d    = active_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;

      // Promotion needs a full slot and a transfer needs an empty one, so the
      // two never coincide: a transfer on a wrap edge waits for the next wrap.
      if (wrap_ev && pend_full_q) begin
         active_d    = pend_q;
         pend_full_d = 1'b0;
      end
      if (xfer) begin
         pend_d      = duty_sat;
         pend_full_d = 1'b1;
      end

      // Compare uses the post-edge duty so a promoted value governs count 0.
      pwm_d  = ({1'b0, iCuenta} < active_d);
      wrap_d = wrap_ev;

      if (!same)
         stall_cnt_d = '0;
      else if (stall_cnt_q == LIMIT)
         stall_cnt_d = stall_cnt_q;
      else
         stall_cnt_d = stall_cnt_q + 8'd1;
      stall_d = (stall_cnt_d == LIMIT);
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         prev_q      <= '0;
         stall_cnt_q <= '0;
         active_q    <= (WIDTH+1)'(DUTY_INIT);
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         pwm_q       <= 1'b0;
         wrap_q      <= 1'b0;
         stall_q     <= 1'b0;
      end else begin
         prev_q      <= prev_d;
         stall_cnt_q <= stall_cnt_d;
         active_q    <= active_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         pwm_q       <= pwm_d;
         wrap_q      <= wrap_d;
         stall_q     <= stall_d;
      end
   end

   assign oDutyReady = !pend_full_q;
   assign oPwm       = pwm_q;
   assign oWrap      = wrap_q;
   assign oStall     = stall_q;

endmodule

// File: tb/tb_count_pwm_stage.sv
module tb_count_pwm_stage;

   logic       iClk = 1'b0;
   logic       iRst = 1'b1;
   logic [3:0] iCuenta = '0;
   logic [4:0] iDuty = '0;
   logic       iDutyValid = 1'b0;
   logic       oDutyReady, oPwm, oWrap, oStall;

   int checks = 0;
   int failures = 0;

   count_pwm_stage #(.WIDTH(4), .STALL_LIMIT(8), .DUTY_INIT(0)) dut (
      .iClk(iClk), .iRst(iRst), .iCuenta(iCuenta), .iDuty(iDuty),
      .iDutyValid(iDutyValid), .oDutyReady(oDutyReady), .oPwm(oPwm),
      .oWrap(oWrap), .oStall(oStall)
   );

   always #5 iClk = ~iClk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply one count sample, clock it, and settle 1 time unit past the edge.
   task automatic step(input int c);
      iCuenta = 4'(c);
      @(posedge iClk);
      #1;
   endtask

   // One full 0..15 period. expd: duty governing this period's PWM.
   // load_c: count at whose edge iDuty=load_v is offered (-1: none).
   // first: period right after reset, where count 0 is not a wrap.
   task automatic period(input int expd, input int load_c, input int load_v,
                         input bit first);
      for (int c = 0; c < 16; c++) begin
         if (c == load_c) begin
            iDutyValid = 1'b1;
            iDuty      = 5'(load_v);
         end
         step(c);
         iDutyValid = 1'b0;
         check_eq("wrap", int'(oWrap), (c == 0 && !first) ? 1 : 0);
         check_eq("pwm", int'(oPwm), (c < expd) ? 1 : 0);
         check_eq("stall", int'(oStall), 0);
         check_eq("ready", int'(oDutyReady), (load_c >= 0 && c >= load_c) ? 0 : 1);
      end
   endtask

   initial begin
      #1;
      check_eq("rst_pwm", int'(oPwm), 0);
      check_eq("rst_wrap", int'(oWrap), 0);
      check_eq("rst_stall", int'(oStall), 0);
      check_eq("rst_ready", int'(oDutyReady), 1);
      #11 iRst = 1'b0;

      // Free running, no loads.
      period(0, -1, 0, 1'b1);
      period(0, -1, 0, 1'b0);
      // Load 4 at count 7, applied at next wrap.
      period(0, 7, 4, 1'b0);
      period(4, -1, 0, 1'b0);
      // Transfer on the wrap edge: current period keeps 4, 8 one period later.
      period(4, 0, 8, 1'b0);
      period(8, -1, 0, 1'b0);
      // Full duty, saturated duty, then zero.
      period(8, 5, 16, 1'b0);
      period(16, -1, 0, 1'b0);
      period(16, 3, 20, 1'b0);
      period(16, 9, 0, 1'b0);
      period(0, -1, 0, 1'b0);

      // Stall: 4->5 is a change, then 9 unchanged samples of 5.
      for (int c = 0; c < 5; c++) step(c);
      for (int i = 0; i < 10; i++) begin
         step(5);
         check_eq("stall_hold", int'(oStall), (i >= 8) ? 1 : 0);
         check_eq("stall_wrap", int'(oWrap), 0);
      end
      step(6);
      check_eq("stall_fall", int'(oStall), 0);
      for (int c = 7; c < 16; c++) step(c);

      // Reset mid-period with 12 pending and oPwm high.
      period(0, 2, 10, 1'b0);
      for (int c = 0; c < 9; c++) begin
         if (c == 6) begin
            iDutyValid = 1'b1;
            iDuty      = 5'd12;
         end
         step(c);
         iDutyValid = 1'b0;
         check_eq("pre_rst_pwm", int'(oPwm), (c < 10) ? 1 : 0);
         check_eq("pre_rst_ready", int'(oDutyReady), (c >= 6) ? 0 : 1);
      end
      #2 iRst = 1'b1;
      #1;
      check_eq("async_pwm", int'(oPwm), 0);
      check_eq("async_wrap", int'(oWrap), 0);
      check_eq("async_stall", int'(oStall), 0);
      check_eq("async_ready", int'(oDutyReady), 1);
      #3 iRst = 1'b0;
      for (int c = 9; c < 16; c++) begin
         step(c);
         check_eq("post_rst_pwm", int'(oPwm), 0);
         check_eq("post_rst_ready", int'(oDutyReady), 1);
      end
      period(0, -1, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/count_pwm_stage.md
Name: count_pwm_stage

Overview:
Downstream consumer of the 4-bit free-running counter. Uses the counter value as a PWM ramp and compares it against a duty register to produce a registered PWM output. A duty value loaded through a valid/ready handshake takes effect only at the counter wrap (MAX->0), so PWM periods never glitch. The block also flags wrap events and a stalled (non-advancing) counter.

Parameters:
WIDTH, 4, width of the incoming count; MAX = 2^WIDTH-1, period = 2^WIDTH cycles
STALL_LIMIT, 8, consecutive unchanged count samples that raise oStall (range 1..255)
DUTY_INIT, 0, active duty after reset (0..2^WIDTH)

Ports:
iClk  input  1  clock, rising edge
iRst  input  1  asynchronous, active-high reset
iCuenta  input  WIDTH  count value from the upstream counter
iDuty  input  WIDTH+1  requested duty, 0..2^WIDTH high cycles per period
iDutyValid  input  1  iDuty is valid
oDutyReady  output  1  block can accept a new duty
oPwm  output  1  registered PWM output
oWrap  output  1  one-cycle pulse, counter wrapped
oStall  output  1  counter not advancing

Behaviour:
- All state is on the rising edge of iClk. iRst clears asynchronously.
- Reset values:
  - oPwm=0, oWrap=0, oStall=0, oDutyReady=1.
  - Active duty=DUTY_INIT. Pending slot empty. Previous-count register=0. Stall counter=0.
- Notation: c_k is iCuenta sampled at edge k; prev holds c_{k-1}.
- Wrap event at edge k: prev==MAX and c_k==0.
  - oWrap=1 for exactly the cycle after edge k.
  - Any other discontinuity (jump, hold, backward step) is not a wrap.
- Duty saturation: iDuty > 2^WIDTH is saturated to 2^WIDTH when captured.
- Handshake:
  - Transfer occurs at an edge where iDutyValid=1 and oDutyReady=1.
  - On transfer, iDuty (saturated) goes to the pending slot and oDutyReady drops the following cycle.
  - iDuty is ignored whenever oDutyReady=0.
- Promotion:
  - At a wrap edge with the pending slot full, active duty <= pending, the slot empties, and oDutyReady=1 from the next cycle.
- Transfer and wrap on the same edge:
  - The wrap sees the slot as empty, so active duty is unchanged.
  - The new value is held pending and applied at the following wrap.
- PWM:
  - At edge k, oPwm <= (c_k < D), zero-extended compare.
  - D is the active duty in effect after edge k, so a promoted duty governs the count-0 cycle of its period.
  - Duty 0: oPwm constantly 0. Duty 2^WIDTH: oPwm constantly 1.
- Stall:
  - Edge with c_k==prev: stall counter increments, saturating at STALL_LIMIT.
  - Edge with c_k!=prev: stall counter clears.
  - oStall <= (updated stall counter == STALL_LIMIT).
  - oStall therefore rises the cycle after the STALL_LIMIT-th consecutive unchanged sample and falls the cycle after the first changed sample.
  - An upstream counter held in its own reset correctly reports stall.
- Reset mid-operation: outputs take reset values immediately. Any pending duty is discarded; no partial period completes.
- Output latency: oPwm, oWrap and oStall are each one cycle behind the sampled count.

Test Plan:
1. Release reset; upstream counts 0..15 repeatedly; no duty loads -> oPwm stays 0; oWrap high one cycle every 16 cycles, the cycle after count 0 is sampled; oStall 0; oDutyReady 1.
2. Load iDuty=4 when count=7 -> oDutyReady 0 next cycle; oPwm stays 0 until the wrap; then oPwm is 1 for counts 0-3 (4 cycles) and 0 for 12 cycles, repeating; oDutyReady returns to 1 the cycle after the wrap edge.
3. Load iDuty=16, then iDuty=20 in a later period -> both give oPwm constantly 1 over full periods; load iDuty=0 -> oPwm 0 from the next period.
4. iDutyValid=1 with iDuty=8, transfer on the edge where count goes 15->0, active duty 4 -> the current period keeps duty 4; duty 8 is applied at the next wrap, 16 cycles later.
5. Hold iCuenta=5 for 10 cycles -> oStall rises the cycle after the 8th unchanged sample and stays high; step to 6 -> oStall falls the next cycle; no oWrap throughout.
6. Assert iRst asynchronously mid-period with duty 12 pending and oPwm=1 -> oPwm, oWrap, oStall go to 0 and oDutyReady to 1 without a clock edge; after release with the counter running, active duty is DUTY_INIT and the pending value never appears.
